// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared MDU definitions: op codes, issue-controller state encoding and op-class helpers.
// Used by the MDU, the decoder and mdu_issue_ctrl.
package mdu_issue_ctrl_pkg;

    localparam logic [3:0] MduNop   = 4'd0;
    localparam logic [3:0] MduMult  = 4'd1;
    localparam logic [3:0] MduMultu = 4'd2;
    localparam logic [3:0] MduDiv   = 4'd3;
    localparam logic [3:0] MduDivu  = 4'd4;
    localparam logic [3:0] MduMfhi  = 4'd5;
    localparam logic [3:0] MduMflo  = 4'd6;
    localparam logic [3:0] MduMthi  = 4'd7;
    localparam logic [3:0] MduMtlo  = 4'd8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIssued = 2'd1,
        StRun    = 2'd2
    } mdu_state_e;

    function automatic logic is_long_op(input logic [3:0] op);
        return (op == MduMult) || (op == MduMultu) || (op == MduDiv) || (op == MduDivu);
    endfunction

    function automatic logic is_hilo_op(input logic [3:0] op);
        return (op >= MduMult) && (op <= MduMtlo);
    endfunction

endpackage

// File: rtl/mdu_issue_ctrl_stall_counter.sv
// mdu_stall_counter: 32-bit saturating event counter with enable and synchronous reset.
module mdu_stall_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_i,
    output logic [31:0] cnt_o
);

    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/mdu_issue_ctrl.sv
// E-stage MDU initiator: start pulse, op gating, in-flight tracking and D-stage HI/LO stall.
// Optional watchdog on a stuck MDU busy flag is enabled by defining MDU_WATCHDOG_EN.
module mdu_issue_ctrl
    import mdu_issue_ctrl_pkg::*;
#(
    parameter int unsigned WD_LIMIT = 32,
    parameter int unsigned CNT_W    = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  d_mdu_op,
    input  logic [3:0]  e_mdu_op,
    input  logic        e_valid,
    input  logic        flush,
    input  logic        mdu_busy,
    output logic        mdu_start,
    output logic [3:0]  mdu_op,
    output logic        stall_d,
    output logic        pending,
`ifdef MDU_WATCHDOG_EN
    output logic        wd_error,
`endif
    output logic [31:0] stall_cnt
);

    localparam logic [CNT_W-1:0] WdLimit = CNT_W'(WD_LIMIT);

    mdu_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             e_ok;
    logic             issue;
    logic             wd_fire;

    assign e_ok      = e_valid & ~flush;
    assign issue     = e_ok & is_long_op(e_mdu_op);
    assign mdu_start = issue & (state_q == StIdle);
    assign mdu_op    = (e_ok && (state_q == StIdle)) ? e_mdu_op : MduNop;
    assign pending   = (state_q != StIdle);

`ifdef MDU_WATCHDOG_EN
    assign wd_fire = (state_q == StRun) & mdu_busy & (cnt_q == WdLimit);
`else
    assign wd_fire = 1'b0;
`endif

    // No stall once busy drops in RUN: HI/LO are written at that edge.
    assign stall_d = is_hilo_op(d_mdu_op) & ~wd_fire &
                     (mdu_start | (state_q == StIssued) | ((state_q == StRun) & mdu_busy));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (issue) begin
                        state_q <= StIssued;
                        cnt_q   <= '0;
                    end
                end
                StIssued: state_q <= StRun;
                StRun: begin
                    if (wd_fire || !mdu_busy) begin
                        state_q <= StIdle;
                    end
                    // Saturate so the debug count never wraps while RUN waits.
                    if (cnt_q != WdLimit) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef MDU_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_error <= 1'b0;
        end else if (wd_fire) begin
            wd_error <= 1'b1;
        end
    end
`endif

    mdu_stall_counter u_stall_counter (
        .clk   (clk),
        .reset (reset),
        .en_i  (stall_d),
        .cnt_o (stall_cnt)
    );

endmodule
